// File: rtl/pingpong_clear_ram_pkg.sv
// Shared types and default geometry for the ping-pong frame memory.
// DEFAULT_DEPTH/ADDR_WIDTH track the display controller's pixel count.
package pingpong_clear_ram_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_CLEARING = 2'd1,
        ST_READY    = 2'd2,
        ST_SWAP     = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH      = 1024;
    localparam int DEFAULT_ADDR_WIDTH = 10;

endpackage

// File: rtl/pingpong_clear_ram_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read-first read port.
module sdp_ram
    import pingpong_clear_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The caller only ever presents in-range write addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if ({1'b0, raddr} < DEPTH_EXT) begin
            rdata <= mem[raddr[IDX_W-1:0]];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/pingpong_clear_ram.sv
// Double-buffered frame memory: the front bank serves the renderer and scan-out
// while the back bank is swept to CLEAR_VALUE; swaps wait for the sweep to finish.
module pingpong_clear_ram
    import pingpong_clear_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 1,
    parameter int                    DEPTH       = DEFAULT_DEPTH,
    parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  swap,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  clear_busy,
    output logic                  swap_pending,
    output logic                  swap_ack,
    output logic                  front_sel
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] count, count_next;
    logic                  front_next;
    logic                  pending_next;
    logic                  sweep_last;
    logic                  user_write;
    logic                  rd_sel;
    logic                  rd_oob;

    logic                  bank_we    [2];
    logic [ADDR_WIDTH-1:0] bank_addr  [2];
    logic [DATA_WIDTH-1:0] bank_wdata [2];
    logic [DATA_WIDTH-1:0] bank_rdata [2];

    assign sweep_last = (count == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            count        <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            front_sel    <= front_next;
            swap_pending <= pending_next;
        end
    end

    // A swap seen on the last sweep cycle is honoured directly rather than lost.
    always_comb begin
        state_next   = state;
        count_next   = count;
        front_next   = front_sel;
        pending_next = swap_pending;
        case (state)
            ST_INIT: begin
                pending_next = swap_pending | swap;
                if (sweep_last) begin
                    count_next = '0;
                    state_next = ST_READY;
                end else begin
                    count_next = count + ADDR_WIDTH'(1);
                end
            end
            ST_CLEARING: begin
                if (sweep_last) begin
                    count_next   = '0;
                    pending_next = 1'b0;
                    state_next   = (swap_pending | swap) ? ST_SWAP : ST_READY;
                end else begin
                    count_next   = count + ADDR_WIDTH'(1);
                    pending_next = swap_pending | swap;
                end
            end
            ST_READY: begin
                count_next   = '0;
                pending_next = 1'b0;
                if (swap | swap_pending) begin
                    state_next = ST_SWAP;
                end
            end
            ST_SWAP: begin
                front_next   = ~front_sel;
                pending_next = swap;
                count_next   = '0;
                state_next   = ST_CLEARING;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign ready      = (state != ST_INIT);
    assign clear_busy = (state == ST_INIT) || (state == ST_CLEARING);
    assign swap_ack   = (state == ST_SWAP);
    assign user_write = we && ready && ({1'b0, write_addr} < DEPTH_EXT);

    // INIT sweeps both banks; CLEARING sweeps only the back bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_addr[b]  = write_addr;
            bank_wdata[b] = write_data;
            if ((state == ST_INIT) || ((state == ST_CLEARING) && (front_sel != 1'(b)))) begin
                bank_we[b]    = 1'b1;
                bank_addr[b]  = count;
                bank_wdata[b] = CLEAR_VALUE;
            end else if (user_write && (front_sel == 1'(b))) begin
                bank_we[b] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        sdp_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we[g]),
            .waddr (bank_addr[g]),
            .wdata (bank_wdata[g]),
            .raddr (read_addr),
            .rdata (bank_rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel <= 1'b0;
            rd_oob <= 1'b0;
        end else begin
            rd_sel <= front_sel;
            rd_oob <= !({1'b0, read_addr} < DEPTH_EXT);
        end
    end

    assign read_data = rd_oob ? CLEAR_VALUE : bank_rdata[rd_sel];

endmodule

// File: tb/tb_pingpong_clear_ram.sv
// Bench for pingpong_clear_ram with DEPTH=16, ADDR_WIDTH=5, DATA_WIDTH=4, CLEAR_VALUE=0.
module tb_pingpong_clear_ram;

    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          swap;
    logic          we;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          ready;
    logic          clear_busy;
    logic          swap_pending;
    logic          swap_ack;
    logic          front_sel;

    always #5 clk = ~clk;

    pingpong_clear_ram #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .CLEAR_VALUE (4'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .swap         (swap),
        .we           (we),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .ready        (ready),
        .clear_busy   (clear_busy),
        .swap_pending (swap_pending),
        .swap_ack     (swap_ack),
        .front_sel    (front_sel)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [DW-1:0] m_bank [2][DEPTH];
    bit            m_started  = 1'b0;
    bit            m_init     = 1'b0;
    bit            m_swapping = 1'b0;
    bit            m_pend     = 1'b0;
    bit            m_front    = 1'b0;
    bit            m_rd_known = 1'b0;
    int            m_left     = 0;
    logic [DW-1:0] m_rd       = '0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // m_left counts sweep cycles still owed; zero means the back bank is clean.
    task automatic model_step();
        int a;
        cyc++;
        if (reset) begin
            m_started  = 1'b1;
            m_init     = 1'b1;
            m_left     = DEPTH;
            m_swapping = 1'b0;
            m_pend     = 1'b0;
            m_front    = 1'b0;
            m_rd       = '0;
            m_rd_known = 1'b1;
            return;
        end
        if (!m_started) return;
        if (int'(read_addr) >= DEPTH) begin
            m_rd       = '0;
            m_rd_known = 1'b1;
        end else begin
            m_rd       = m_bank[m_front][int'(read_addr)];
            m_rd_known = !m_init;
        end
        if (we && !m_init && int'(write_addr) < DEPTH)
            m_bank[m_front][int'(write_addr)] = write_data;
        if (m_left > 0) begin
            a = DEPTH - m_left;
            if (m_init) begin
                m_bank[0][a] = '0;
                m_bank[1][a] = '0;
            end else begin
                m_bank[!m_front][a] = '0;
            end
        end
        if (m_swapping) begin
            m_front    = !m_front;
            m_swapping = 1'b0;
            m_pend     = swap;
            m_left     = DEPTH;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_init) begin
                    m_init = 1'b0;
                    m_pend = m_pend || swap;
                end else if (m_pend || swap) begin
                    m_swapping = 1'b1;
                    m_pend     = 1'b0;
                end
            end else begin
                m_pend = m_pend || swap;
            end
        end else if (swap || m_pend) begin
            m_swapping = 1'b1;
            m_pend     = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_started) begin
            check_output("model_ready",        ready,        m_init ? 0 : 1);
            check_output("model_clear_busy",   clear_busy,   (m_left > 0) ? 1 : 0);
            check_output("model_swap_ack",     swap_ack,     m_swapping);
            check_output("model_swap_pending", swap_pending, m_pend);
            check_output("model_front_sel",    front_sel,    m_front);
            if (m_rd_known) check_output("model_read_data", read_data, m_rd);
        end
    end

    task automatic apply_stimulus(input logic rst, input logic sw, input logic w,
                                  input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                  input logic [AW-1:0] ra);
        reset      = rst;
        swap       = sw;
        we         = w;
        write_addr = wa;
        write_data = wd;
        read_addr  = ra;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, '0, '0, '0);
    endtask

    task automatic read_expect(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
        apply_stimulus(0, 0, 0, '0, '0, addr);
        check_output(name, read_data, exp);
    endtask

    task automatic wait_ack(input string name);
        int i = 0;
        while (swap_ack !== 1'b1 && i < 40) begin
            idle(1);
            i++;
        end
        check_output(name, swap_ack, 1);
    endtask

    initial begin
        int t_ack1;
        int t_ack2;
        int ack_count;
        reset = 1'b1; swap = 1'b0; we = 1'b0;
        write_addr = '0; write_data = '0; read_addr = '0;

        apply_stimulus(1, 0, 0, '0, '0, '0);
        check_output("reset_ready",     ready,      0);
        check_output("reset_busy",      clear_busy, 1);
        check_output("reset_front",     front_sel,  0);
        check_output("reset_read_data", read_data,  0);

        idle(15);
        check_output("t1_init_still_busy", ready, 0);
        idle(1);
        check_output("t1_ready_after_16", ready,      1);
        check_output("t1_busy_after_16",  clear_busy, 0);
        for (int i = 0; i < DEPTH; i++) read_expect(AW'(i), 4'h0, "t1_bank0_clear");
        apply_stimulus(0, 1, 0, '0, '0, '0);
        check_output("t1_swap_ack", swap_ack, 1);
        idle(1);
        for (int i = 0; i < DEPTH; i++) read_expect(AW'(i), 4'h0, "t1_bank1_clear");
        idle(20);
        apply_stimulus(0, 1, 0, '0, '0, '0);
        wait_ack("t1_swap_back_ack");
        idle(20);
        check_output("t1_front_back_to_0", front_sel, 0);

        apply_stimulus(0, 0, 1, 5'd3, 4'hA, '0);
        read_expect(5'd3, 4'hA, "t2_read_written");
        apply_stimulus(0, 1, 0, '0, '0, '0);
        check_output("t2_ack_one_cycle", swap_ack,  1);
        check_output("t2_front_before",  front_sel, 0);
        t_ack1 = cyc;

        apply_stimulus(0, 1, 0, '0, '0, '0);
        check_output("t3_front_after_swap", front_sel,    1);
        check_output("t3_pending_set",      swap_pending, 1);
        check_output("t3_ack_held_off",     swap_ack,     0);
        read_expect(5'd3, 4'h0, "t2_read_after_swap");
        wait_ack("t3_deferred_ack");
        t_ack2 = cyc;
        check_output("t3_ack_spacing", t_ack2 - t_ack1, 17);
        idle(1);
        check_output("t3_front_back", front_sel, 0);
        read_expect(5'd3, 4'h0, "t3_old_data_cleared");

        ack_count = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(0, (i == 2 || i == 5 || i == 9), 0, '0, '0, '0);
            if (swap_ack === 1'b1) ack_count++;
        end
        check_output("t4_single_ack",     ack_count, 1);
        check_output("t4_front_toggled",  front_sel, 1);
        idle(20);
        check_output("t4_ready_again", clear_busy, 0);

        apply_stimulus(0, 0, 1, 5'd20, 4'hF, '0);
        read_expect(5'd20, 4'h0, "t5_oob_read");
        read_expect(5'd4,  4'h0, "t5_alias_read");
        apply_stimulus(0, 1, 0, '0, '0, '0);
        check_output("t5_swap_ack", swap_ack, 1);
        apply_stimulus(0, 0, 1, 5'd5, 4'h7, '0);
        read_expect(5'd5, 4'h0, "t5_new_front_untouched");
        idle(20);
        apply_stimulus(0, 1, 0, '0, '0, '0);
        wait_ack("t5_swap_back_ack");
        idle(1);
        read_expect(5'd5, 4'h0, "t5_ack_write_cleared");

        idle(20);
        apply_stimulus(0, 0, 1, 5'd2, 4'h9, '0);
        read_expect(5'd2, 4'h9, "t6_pre_write");
        apply_stimulus(0, 1, 0, '0, '0, '0);
        idle(1);
        apply_stimulus(0, 0, 1, 5'd6, 4'h3, '0);
        apply_stimulus(0, 1, 0, '0, '0, '0);
        check_output("t6_pending_before_reset", swap_pending, 1);
        idle(5);
        apply_stimulus(1, 0, 0, '0, '0, '0);
        check_output("t6_front_reset",   front_sel,    0);
        check_output("t6_pending_reset", swap_pending, 0);
        check_output("t6_ready_low",     ready,        0);
        idle(15);
        check_output("t6_init_15", ready, 0);
        idle(1);
        check_output("t6_init_done", ready, 1);
        read_expect(5'd6, 4'h0, "t6_bank0_cleared");
        apply_stimulus(0, 1, 0, '0, '0, '0);
        wait_ack("t6_swap_ack");
        idle(1);
        read_expect(5'd2, 4'h0, "t6_bank1_cleared");

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
